// File: rtl/object_frontend_pkg.sv
// Shared Q-format widths, angle constants, controlPad bit map and the
// inMtrx element-offset helper for the object front-end.
package object_frontend_pkg;

    localparam int Q_W = 21;  // Q1.10.10 position / vertex width
    localparam int A_W = 16;  // Q1.2.13 angle width

    localparam logic signed [A_W-1:0] PI     = 16'sd25736;
    localparam logic signed [A_W:0]   TWO_PI = 17'sd51472;
    localparam logic signed [Q_W-1:0] ONE    = 21'sd1024;

    localparam int PAD_XP  = 0;
    localparam int PAD_XN  = 1;
    localparam int PAD_YP  = 2;
    localparam int PAD_YN  = 3;
    localparam int PAD_ZP  = 4;
    localparam int PAD_ZN  = 5;
    localparam int PAD_AXP = 6;
    localparam int PAD_AXN = 7;
    localparam int PAD_AYP = 8;
    localparam int PAD_AYN = 9;
    localparam int PAD_AZP = 10;
    localparam int PAD_AZN = 11;

    // Low bit of element (row, col) in the packed 4x4 matrix.
    function automatic int mtrx_lo(input int row, input int col);
        return Q_W * (4 * row + col);
    endfunction

endpackage

// File: rtl/object_frontend_fclk_rise_det.sv
// Brings the slow frame clock into the CLK domain and emits a one-cycle
// pulse on each of its rising edges.
module fclk_rise_det (
    input  logic CLK,
    input  logic rst,
    input  logic fclk,
    output logic fclk_rise
);

    logic [1:0] sync;
    logic       hist;

    // Reset to 1 so a high fclk at reset release is not mistaken for an edge.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            hist <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make the three flops shift as a chain;
            // blocking ones would collapse them into a single stage.
            sync <= {sync[0], fclk};
            hist <= sync[1];
        end
    end

    assign fclk_rise = sync[1] & ~hist;

endmodule

// File: rtl/object_frontend.sv
// Object pose update and vertex-matrix packing for the transform pipeline.
// Optional macro ANGLE_WRAP_EN: angles wrap at +/-PI instead of saturating.
module object_frontend
    import object_frontend_pkg::*;
#(
    parameter logic signed [Q_W-1:0] HALF      = 21'sd1024,
    parameter logic signed [Q_W-1:0] MOVE_STEP = 21'sd1024,
    parameter logic signed [A_W-1:0] ANG_STEP  = 16'sd1024,
    parameter logic signed [Q_W-1:0] POS_LIMIT = 21'sd102400,
    parameter logic signed [Q_W-1:0] INIT_ZC   = -21'sd5120
) (
    input  logic                    CLK,
    input  logic                    rst,
    input  logic                    fclk,
    input  logic [11:0]             controlPad,
    output logic                    fclk_rise,
    output logic signed [Q_W-1:0]   Xc,
    output logic signed [Q_W-1:0]   Yc,
    output logic signed [Q_W-1:0]   Zc,
    output logic signed [Q_W-1:0]   vtx1_X,
    output logic signed [Q_W-1:0]   vtx1_Y,
    output logic signed [Q_W-1:0]   vtx1_Z,
    output logic signed [Q_W-1:0]   vtx2_X,
    output logic signed [Q_W-1:0]   vtx2_Y,
    output logic signed [Q_W-1:0]   vtx2_Z,
    output logic signed [Q_W-1:0]   vtx3_X,
    output logic signed [Q_W-1:0]   vtx3_Y,
    output logic signed [Q_W-1:0]   vtx3_Z,
    output logic signed [Q_W-1:0]   vtx4_X,
    output logic signed [Q_W-1:0]   vtx4_Y,
    output logic signed [Q_W-1:0]   vtx4_Z,
    output logic signed [A_W-1:0]   angleX,
    output logic signed [A_W-1:0]   angleY,
    output logic signed [A_W-1:0]   angleZ,
    output logic signed [16*Q_W-1:0] inMtrx
);

    // One extra bit of headroom so step-then-clamp/wrap never overflows.
    localparam logic signed [Q_W:0] MOVE_X = MOVE_STEP;
    localparam logic signed [Q_W:0] LIM_X  = POS_LIMIT;
    localparam logic signed [A_W:0] ANG_X  = ANG_STEP;
    localparam logic signed [A_W:0] PI_X   = PI;

    localparam logic signed [Q_W-1:0] VX [4] = '{HALF,  HALF, -HALF, -HALF};
    localparam logic signed [Q_W-1:0] VY [4] = '{HALF, -HALF,  HALF, -HALF};
    localparam logic signed [Q_W-1:0] VZ [4] = '{HALF, -HALF, -HALF,  HALF};

    fclk_rise_det u_rise (
        .CLK       (CLK),
        .rst       (rst),
        .fclk      (fclk),
        .fclk_rise (fclk_rise)
    );

    function automatic logic signed [Q_W-1:0] pos_next(
        input logic signed [Q_W-1:0] cur,
        input logic                  inc,
        input logic                  dec
    );
        logic signed [Q_W:0] sum;
        sum = Q_W'(0) + cur;
        sum = cur;
        if (inc && !dec)
            sum = sum + MOVE_X;
        else if (dec && !inc)
            sum = sum - MOVE_X;
        if (sum > LIM_X)
            return POS_LIMIT;
        else if (sum < -LIM_X)
            return -POS_LIMIT;
        return sum[Q_W-1:0];
    endfunction

    function automatic logic signed [A_W-1:0] ang_next(
        input logic signed [A_W-1:0] cur,
        input logic                  inc,
        input logic                  dec
    );
        logic signed [A_W:0] sum;
        sum = cur;
        if (inc && !dec)
            sum = sum + ANG_X;
        else if (dec && !inc)
            sum = sum - ANG_X;
`ifdef ANGLE_WRAP_EN
        if (sum > PI_X)
            sum = sum - TWO_PI;
        else if (sum < -PI_X)
            sum = sum + TWO_PI;
        return sum[A_W-1:0];
`else
        if (sum > PI_X)
            return PI;
        else if (sum < -PI_X)
            return -PI;
        return sum[A_W-1:0];
`endif
    endfunction

    // controlPad is only looked at on the edge that closes a fclk_rise cycle.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            Xc     <= '0;
            Yc     <= '0;
            Zc     <= INIT_ZC;
            angleX <= '0;
            angleY <= '0;
            angleZ <= '0;
        end else if (fclk_rise) begin
            Xc     <= pos_next(Xc, controlPad[PAD_XP], controlPad[PAD_XN]);
            Yc     <= pos_next(Yc, controlPad[PAD_YP], controlPad[PAD_YN]);
            Zc     <= pos_next(Zc, controlPad[PAD_ZP], controlPad[PAD_ZN]);
            angleX <= ang_next(angleX, controlPad[PAD_AXP], controlPad[PAD_AXN]);
            angleY <= ang_next(angleY, controlPad[PAD_AYP], controlPad[PAD_AYN]);
            angleZ <= ang_next(angleZ, controlPad[PAD_AZP], controlPad[PAD_AZN]);
        end
    end

    assign vtx1_X = VX[0];
    assign vtx1_Y = VY[0];
    assign vtx1_Z = VZ[0];
    assign vtx2_X = VX[1];
    assign vtx2_Y = VY[1];
    assign vtx2_Z = VZ[1];
    assign vtx3_X = VX[2];
    assign vtx3_Y = VY[2];
    assign vtx3_Z = VZ[2];
    assign vtx4_X = VX[3];
    assign vtx4_Y = VY[3];
    assign vtx4_Z = VZ[3];

    always_comb begin
        // NOTE: a full default before the loop guarantees every bit is driven,
        // so no latch can be inferred.
        inMtrx = '0;
        for (int c = 0; c < 4; c++) begin
            inMtrx[mtrx_lo(0, c) +: Q_W] = VX[c];
            inMtrx[mtrx_lo(1, c) +: Q_W] = VY[c];
            inMtrx[mtrx_lo(2, c) +: Q_W] = VZ[c];
            inMtrx[mtrx_lo(3, c) +: Q_W] = ONE;
        end
    end

endmodule

// File: tb/tb_object_frontend.sv
// Scoreboard bench for object_frontend: each issued frame pushes the expected
// pose, a monitor pops and compares after every fclk_rise pulse.
module tb_object_frontend;

    logic              CLK = 1'b0;
    logic              rst;
    logic              fclk;
    logic [11:0]       controlPad;
    logic              fclk_rise;
    logic signed [20:0] Xc, Yc, Zc;
    logic signed [20:0] vtx1_X, vtx1_Y, vtx1_Z, vtx2_X, vtx2_Y, vtx2_Z;
    logic signed [20:0] vtx3_X, vtx3_Y, vtx3_Z, vtx4_X, vtx4_Y, vtx4_Z;
    logic signed [15:0] angleX, angleY, angleZ;
    logic [335:0]       inMtrx;

    typedef struct {
        int x, y, z, ax, ay, az;
    } pose_t;

    pose_t exp_q[$];
    pose_t m;
    int    tests = 0;
    int    fails = 0;
    int    pulses = 0;

    always #5 CLK = ~CLK;

    object_frontend dut (
        .CLK(CLK), .rst(rst), .fclk(fclk), .controlPad(controlPad),
        .fclk_rise(fclk_rise), .Xc(Xc), .Yc(Yc), .Zc(Zc),
        .vtx1_X(vtx1_X), .vtx1_Y(vtx1_Y), .vtx1_Z(vtx1_Z),
        .vtx2_X(vtx2_X), .vtx2_Y(vtx2_Y), .vtx2_Z(vtx2_Z),
        .vtx3_X(vtx3_X), .vtx3_Y(vtx3_Y), .vtx3_Z(vtx3_Z),
        .vtx4_X(vtx4_X), .vtx4_Y(vtx4_Y), .vtx4_Z(vtx4_Z),
        .angleX(angleX), .angleY(angleY), .angleZ(angleZ),
        .inMtrx(inMtrx)
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic int pos_step(input int cur, input bit p, input bit n);
        int r;
        r = cur + ((p && !n) ? 1024 : 0) - ((n && !p) ? 1024 : 0);
        if (r > 102400) r = 102400;
        if (r < -102400) r = -102400;
        return r;
    endfunction

    function automatic int ang_step(input int cur, input bit p, input bit n);
        int r;
        r = cur + ((p && !n) ? 1024 : 0) - ((n && !p) ? 1024 : 0);
`ifdef ANGLE_WRAP_EN
        if (r > 25736) r = r - 51472;
        if (r < -25736) r = r + 51472;
`else
        if (r > 25736) r = 25736;
        if (r < -25736) r = -25736;
`endif
        return r;
    endfunction

    // One frame: 8 CLK high, 8 CLK low on fclk, with pad held throughout.
    task automatic frame(input logic [11:0] pad);
        @(negedge CLK);
        controlPad = pad;
        m.x  = pos_step(m.x,  pad[0],  pad[1]);
        m.y  = pos_step(m.y,  pad[2],  pad[3]);
        m.z  = pos_step(m.z,  pad[4],  pad[5]);
        m.ax = ang_step(m.ax, pad[6],  pad[7]);
        m.ay = ang_step(m.ay, pad[8],  pad[9]);
        m.az = ang_step(m.az, pad[10], pad[11]);
        exp_q.push_back(m);
        fclk = 1'b1;
        repeat (8) @(negedge CLK);
        fclk = 1'b0;
        repeat (8) @(negedge CLK);
    endtask

    task automatic drain();
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge CLK);
        check("queue_drained", exp_q.size(), 0);
    endtask

    // Monitor: the pose settles on the edge that ends the pulse.
    initial begin
        forever begin
            @(negedge CLK);
            if (fclk_rise === 1'b1) begin
                pulses++;
                @(posedge CLK);
                #1;
                if (exp_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    pose_t e;
                    e = exp_q.pop_front();
                    check("Xc", int'(Xc), e.x);
                    check("Yc", int'(Yc), e.y);
                    check("Zc", int'(Zc), e.z);
                    check("angleX", int'(angleX), e.ax);
                    check("angleY", int'(angleY), e.ay);
                    check("angleZ", int'(angleZ), e.az);
                end
                @(negedge CLK);
                check("pulse_width", int'(fclk_rise), 0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        fclk = 1'b1;
        controlPad = '0;
        m = '{x: 0, y: 0, z: -5120, ax: 0, ay: 0, az: 0};
        repeat (3) @(negedge CLK);
        rst = 1'b0;
        repeat (6) @(negedge CLK);
        check("reset_no_pulse", pulses, 0);
        check("reset_Xc", int'(Xc), 0);
        check("reset_Zc", int'(Zc), -5120);
        check("reset_angleX", int'(angleX), 0);
        check("mtrx_vtx1_X", int'($signed(inMtrx[20:0])), 1024);
        check("mtrx_vtx2_X", int'($signed(inMtrx[41:21])), 1024);
        check("mtrx_vtx3_X", int'($signed(inMtrx[62:42])), -1024);
        check("mtrx_vtx1_Y", int'($signed(inMtrx[104:84])), 1024);
        check("mtrx_row3_c3", int'($signed(inMtrx[335:315])), 1024);
        check("vtx4_Z", int'(vtx4_Z), 1024);
        fclk = 1'b0;
        repeat (16) @(negedge CLK);

        for (int i = 0; i < 10; i++) frame(12'h000);
        drain();
        check("pulse_count", pulses, 10);

        for (int i = 0; i < 3; i++) frame(12'h001);
        drain();
        check("Xc_after_3", int'(Xc), 3072);

        frame(12'h003);
        drain();
        check("Xc_hold_both", int'(Xc), 3072);

        @(negedge CLK);
        controlPad = 12'h015;
        repeat (20) @(negedge CLK);
        check("Xc_no_edge", int'(Xc), 3072);
        check("Zc_no_edge", int'(Zc), -5120);

        frame(12'h218);
        frame(12'h218);
        drain();
        check("Yc_minus2", int'(Yc), -2048);
        check("Zc_plus2", int'(Zc), -3072);
        check("angleY_minus2", int'(angleY), -2048);

        for (int i = 0; i < 25; i++) frame(12'h040);
        drain();
        check("angleX_25", int'(angleX), 25600);
        frame(12'h040);
        drain();
`ifdef ANGLE_WRAP_EN
        check("angleX_26_wrap", int'(angleX), -24848);
`else
        check("angleX_26_sat", int'(angleX), 25736);
`endif

        // Reset while an edge is in the synchronizer: pose clears, no pulse.
        @(negedge CLK);
        fclk = 1'b1;
        @(negedge CLK);
        rst = 1'b1;
        m = '{x: 0, y: 0, z: -5120, ax: 0, ay: 0, az: 0};
        #1;
        check("midreset_Xc", int'(Xc), 0);
        check("midreset_angleX", int'(angleX), 0);
        repeat (2) @(negedge CLK);
        rst = 1'b0;
        repeat (10) @(negedge CLK);
        check("midreset_no_pulse", pulses, 10 + 3 + 1 + 2 + 26);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
